spi_master: RTL and testbench

- Host-side SPI initiator that drives one transaction at a time into the on-chip SPI slave: 7-bit address, R/W bit, 8 data bits, 16 SCLK periods per frame.
- Generates CS, SCLK and MOSI.
- Samples MISO during the data byte of reads and returns the byte to the host over a start/done handshake.
- Sits between the host bus logic and the SPI pins; used as a bench driver for the slave and as the master in loopback builds.

---
 rtl/spi_master.sv | 156 +++++++++++++++
 tb/tb_spi_master.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_master.sv
// SPI initiator: one 16-bit frame {addr[6:0], rw, data[7:0]} per request, MSB first, SCLK idles low.
// Define SPI_MASTER_LOOPBACK_EN to add a loopback input that feeds internal MOSI into the read sampler.
`timescale 1ns/1ps
module spi_master #(
  parameter int CLK_DIV = 4,
  parameter int CS_GAP  = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic [6:0] addr,
  input  logic       rw,
  input  logic [7:0] wdata,
`ifdef SPI_MASTER_LOOPBACK_EN
  input  logic       loopback,
`endif
  output logic       ready,
  output logic       done,
  output logic [7:0] rdata,
  output logic       cs,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_HIGH, S_LOW, S_GAP} state_e;

  localparam logic [7:0] DIV_LOAD = 8'(CLK_DIV - 1);
  // cs is also high during the IDLE cycle that accepts the next frame, so GAP
  // itself (done cycle included) lasts CS_GAP-1 cycles to give CS_GAP high cycles.
  localparam logic [7:0] GAP_LOAD = 8'((CS_GAP > 1) ? (CS_GAP - 2) : 0);

  state_e      state_q, state_d;
  logic [7:0]  div_q, div_d;
  logic [3:0]  bit_q, bit_d;
  logic [15:0] tx_q, tx_d;
  logic [7:0]  rx_q, rx_d;
  logic        rw_q, rw_d;
  logic        cs_q, cs_d;
  logic        sclk_q, sclk_d;
  logic        done_q, done_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        miso_s;

`ifdef SPI_MASTER_LOOPBACK_EN
  assign miso_s = loopback ? tx_q[15] : miso;
`else
  assign miso_s = miso;
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default first so no path leaves one unassigned (no latches).
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    tx_d    = tx_q;
    rx_d    = rx_q;
    rw_d    = rw_q;
    cs_d    = cs_q;
    sclk_d  = sclk_q;
    done_d  = 1'b0;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_SETUP;
          tx_d    = {addr, rw, wdata};
          rw_d    = rw;
          rx_d    = '0;
          div_d   = DIV_LOAD;
          bit_d   = '0;
          cs_d    = 1'b0;
        end
      end
      S_SETUP: begin
        if (div_q == '0) begin
          state_d = S_HIGH;
          sclk_d  = 1'b1;
          div_d   = DIV_LOAD;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_HIGH: begin
        if (div_q == '0) begin
          state_d = S_LOW;
          sclk_d  = 1'b0;
          tx_d    = {tx_q[14:0], 1'b0};  // after the 16th shift mosi reads 0
          div_d   = DIV_LOAD;
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_LOW: begin
        if (div_q == '0) begin
          if (bit_q == 4'd15) begin
            cs_d    = 1'b1;
            done_d  = 1'b1;
            bit_d   = '0;
            div_d   = GAP_LOAD;
            state_d = (CS_GAP > 1) ? S_GAP : S_IDLE;
            if (rw_q) rdata_d = rx_q;
          end else begin
            state_d = S_HIGH;
            sclk_d  = 1'b1;
            bit_d   = bit_q + 4'd1;
            div_d   = DIV_LOAD;
            if (rw_q && bit_q >= 4'd7) rx_d = {rx_q[6:0], miso_s};
          end
        end else begin
          div_d = div_q - 8'd1;
        end
      end
      S_GAP: begin
        if (div_q == '0) state_d = S_IDLE;
        else             div_d   = div_q - 8'd1;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments and reset asynchronously; cs idles high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      tx_q    <= '0;
      rx_q    <= '0;
      rw_q    <= 1'b0;
      cs_q    <= 1'b1;
      sclk_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      tx_q    <= tx_d;
      rx_q    <= rx_d;
      rw_q    <= rw_d;
      cs_q    <= cs_d;
      sclk_q  <= sclk_d;
      done_q  <= done_d;
      rdata_q <= rdata_d;
    end
  end

  assign ready = (state_q == S_IDLE);
  assign done  = done_q;
  assign rdata = rdata_q;
  assign cs    = cs_q;
  assign sclk  = sclk_q;
  assign mosi  = tx_q[15];

endmodule

// File: tb/tb_spi_master.sv
// Bench for spi_master: three instances (CLK_DIV 4/2/1), a pin-level monitor/slave model and a frame scoreboard.
`timescale 1ns/1ps
module tb_spi_master;
  localparam int N = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic       start [N];
  logic [6:0] addr  [N];
  logic       rw    [N];
  logic [7:0] wdata [N];
  logic       ready [N];
  logic       done  [N];
  logic [7:0] rdata [N];
  logic       cs    [N];
  logic       sclk  [N];
  logic       mosi  [N];
  logic       miso  [N];
`ifdef SPI_MASTER_LOOPBACK_EN
  logic       loopback [N];
`endif

  spi_master #(.CLK_DIV(4), .CS_GAP(8)) u_dut0 (
    .clk(clk), .rst_n(rst_n), .start(start[0]), .addr(addr[0]), .rw(rw[0]), .wdata(wdata[0]),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback[0]),
`endif
    .ready(ready[0]), .done(done[0]), .rdata(rdata[0]), .cs(cs[0]), .sclk(sclk[0]),
    .mosi(mosi[0]), .miso(miso[0]));

  spi_master #(.CLK_DIV(2), .CS_GAP(8)) u_dut1 (
    .clk(clk), .rst_n(rst_n), .start(start[1]), .addr(addr[1]), .rw(rw[1]), .wdata(wdata[1]),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback[1]),
`endif
    .ready(ready[1]), .done(done[1]), .rdata(rdata[1]), .cs(cs[1]), .sclk(sclk[1]),
    .mosi(mosi[1]), .miso(miso[1]));

  spi_master #(.CLK_DIV(1), .CS_GAP(3)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .start(start[2]), .addr(addr[2]), .rw(rw[2]), .wdata(wdata[2]),
`ifdef SPI_MASTER_LOOPBACK_EN
    .loopback(loopback[2]),
`endif
    .ready(ready[2]), .done(done[2]), .rdata(rdata[2]), .cs(cs[2]), .sclk(sclk[2]),
    .mosi(mosi[2]), .miso(miso[2]));

  // Pin monitor and slave model, sampled on the falling clk edge.
  int          cyc = 0;
  logic        prev_cs      [N] = '{default: 1'b1};
  logic        prev_sclk    [N] = '{default: 1'b0};
  logic        prev_done    [N] = '{default: 1'b0};
  int          bit_cnt      [N] = '{default: 0};
  logic [15:0] cap          [N] = '{default: 16'h0};
  int          frames       [N] = '{default: 0};
  int          done_cyc     [N] = '{default: 0};
  logic [15:0] word         [N] = '{default: 16'h0};
  int          rises        [N] = '{default: 0};
  logic [7:0]  rd_at_done   [N] = '{default: 8'h0};
  int          done_long    [N] = '{default: 0};
  int          total_rise   [N] = '{default: 0};
  int          rise_cs_high [N] = '{default: 0};
  int          high_run     [N] = '{default: 0};
  int          last_gap     [N] = '{default: 0};
  int          cs_fall_cyc  [N] = '{default: 0};
  int          cs_rise_cyc  [N] = '{default: 0};
  logic [7:0]  slave_byte   [N] = '{default: 8'h0};

  always @(negedge clk) begin
    cyc = cyc + 1;
    for (int i = 0; i < N; i++) begin
      if (cs[i]) begin
        high_run[i] = high_run[i] + 1;
      end else if (prev_cs[i]) begin
        last_gap[i]    = high_run[i];
        high_run[i]    = 0;
        bit_cnt[i]     = 0;
        cap[i]         = '0;
        cs_fall_cyc[i] = cyc;
      end
      if (cs[i] && !prev_cs[i]) cs_rise_cyc[i] = cyc;
      if (sclk[i] && !prev_sclk[i]) begin
        total_rise[i] = total_rise[i] + 1;
        if (cs[i]) rise_cs_high[i] = rise_cs_high[i] + 1;
        else begin
          cap[i]     = {cap[i][14:0], mosi[i]};
          bit_cnt[i] = bit_cnt[i] + 1;
        end
      end
      if (!sclk[i] && prev_sclk[i])
        miso[i] = (bit_cnt[i] >= 8 && bit_cnt[i] < 16) ? slave_byte[i][3'(15 - bit_cnt[i])] : 1'b0;
      if (done[i]) begin
        if (prev_done[i]) done_long[i] = done_long[i] + 1;
        else begin
          frames[i]     = frames[i] + 1;
          done_cyc[i]   = cyc;
          word[i]       = cap[i];
          rises[i]      = bit_cnt[i];
          rd_at_done[i] = rdata[i];
        end
      end
      prev_cs[i]   = cs[i];
      prev_sclk[i] = sclk[i];
      prev_done[i] = done[i];
    end
  end

  // Scoreboard: expected frames pushed on accept, popped when done is seen.
  typedef struct {
    int          inst;
    logic [15:0] word;
    logic [7:0]  rdata;
  } exp_t;

  exp_t       sb [$];
  logic [7:0] model_rdata [N] = '{default: 8'h0};
  int         seen    [N] = '{default: 0};
  int         acc_cyc [N] = '{default: 0};
  int         errors = 0;
  int         checks = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp_v);
    end
  endtask

  task automatic send(input int i, input logic [6:0] a, input logic r, input logic [7:0] w,
                      input bit hold, input bit lb);
    bit   ok = 1'b0;
    exp_t e;
    for (int k = 0; k < 400; k++) begin
      if (ready[i]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check($sformatf("ready_wait%0d", i), 32'(ok), 32'd1);
    start[i] = 1'b1; addr[i] = a; rw[i] = r; wdata[i] = w;
    @(posedge clk);
    acc_cyc[i] = cyc;
    if (r) model_rdata[i] = lb ? w : slave_byte[i];
    e.inst = i; e.word = {a, r, w}; e.rdata = model_rdata[i];
    sb.push_back(e);
    #1;
    if (!hold) start[i] = 1'b0;
  endtask

  task automatic finish_frame(input int i, input int budget);
    bit   ok = 1'b0;
    exp_t e;
    for (int k = 0; k < budget; k++) begin
      if (frames[i] > seen[i]) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check($sformatf("done_timeout%0d", i), 32'(ok), 32'd1);
    if (ok) begin
      seen[i] = seen[i] + 1;
      e = sb.pop_front();
      check($sformatf("sb_inst%0d", i), 32'(e.inst), 32'(i));
      check($sformatf("mosi_word%0d", i), 32'(word[i]), 32'(e.word));
      check($sformatf("sclk_rises%0d", i), 32'(rises[i]), 32'd16);
      check($sformatf("rdata%0d", i), 32'(rd_at_done[i]), 32'(e.rdata));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int f;
    int r0;
    for (int i = 0; i < N; i++) begin
      start[i] = 1'b0; addr[i] = '0; rw[i] = 1'b0; wdata[i] = '0;
`ifdef SPI_MASTER_LOOPBACK_EN
      loopback[i] = 1'b0;
`endif
    end
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("rst_ready%0d", i), 32'(ready[i]), 32'd1);
      check($sformatf("rst_cs%0d", i),    32'(cs[i]),    32'd1);
      check($sformatf("rst_sclk%0d", i),  32'(sclk[i]),  32'd0);
      check($sformatf("rst_mosi%0d", i),  32'(mosi[i]),  32'd0);
      check($sformatf("rst_done%0d", i),  32'(done[i]),  32'd0);
      check($sformatf("rst_rdata%0d", i), 32'(rdata[i]), 32'd0);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Write at CLK_DIV=4 with a competing start mid-frame.
    send(0, 7'h2A, 1'b0, 8'hC3, 1'b0, 1'b0);
    repeat (40) @(negedge clk);
    check("busy_ready", 32'(ready[0]), 32'd0);
    start[0] = 1'b1; addr[0] = 7'h7F; rw[0] = 1'b1; wdata[0] = 8'hFF;
    repeat (10) @(negedge clk);
    start[0] = 1'b0;
    finish_frame(0, 300);
    check("wr_done_cycle", 32'(done_cyc[0] - acc_cyc[0]), 32'd133);
    check("wr_cs_fall",    32'(cs_fall_cyc[0] - acc_cyc[0]), 32'd1);
    check("wr_cs_rise",    32'(cs_rise_cyc[0] - acc_cyc[0]), 32'd133);
    check("wr_one_done",   32'(frames[0]), 32'd1);

    // Start held through the gap: accepted only in the first ready cycle.
    start[0] = 1'b1; addr[0] = 7'h11; rw[0] = 1'b0; wdata[0] = 8'h5A;
    r0 = done_cyc[0];
    send(0, 7'h11, 1'b0, 8'h5A, 1'b0, 1'b0);
    check("gap_accept", 32'(acc_cyc[0] - r0), 32'd7);
    finish_frame(0, 300);
    check("gap_cs_high", 32'(last_gap[0]), 32'd8);

    // Read at CLK_DIV=2, slave returns 0x9E.
    slave_byte[1] = 8'h9E;
    send(1, 7'h05, 1'b1, 8'h00, 1'b0, 1'b0);
    finish_frame(1, 300);
    check("rd_done_cycle", 32'(done_cyc[1] - acc_cyc[1]), 32'd67);

    // Reset in the middle of a read frame.
    send(1, 7'h33, 1'b1, 8'h00, 1'b0, 1'b0);
    sb.delete(sb.size() - 1);
    r0 = 0;
    for (int k = 0; k < 200; k++) begin
      if (bit_cnt[1] >= 6) begin r0 = 1; break; end
      @(negedge clk);
    end
    check("mid_bit6_seen", 32'(r0), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_cs",    32'(cs[1]),    32'd1);
    check("mid_rst_sclk",  32'(sclk[1]),  32'd0);
    check("mid_rst_mosi",  32'(mosi[1]),  32'd0);
    check("mid_rst_rdata", 32'(rdata[1]), 32'd0);
    check("mid_rst_ready", 32'(ready[1]), 32'd1);
    f = frames[1];
    for (int i = 0; i < N; i++) model_rdata[i] = 8'h00;
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    check("mid_no_done", 32'(frames[1]), 32'(f));
    send(1, 7'h40, 1'b0, 8'h3C, 1'b0, 1'b0);
    finish_frame(1, 300);

    // Back-to-back at CLK_DIV=1, CS_GAP=3 with start held high.
    slave_byte[2] = 8'h5C;
    f = total_rise[2];
    send(2, 7'h15, 1'b0, 8'h96, 1'b1, 1'b0);
    addr[2] = 7'h6B; rw[2] = 1'b1; wdata[2] = 8'h0F;
    finish_frame(2, 200);
    send(2, 7'h6B, 1'b1, 8'h0F, 1'b0, 1'b0);
    finish_frame(2, 200);
    check("b2b_cs_high", 32'(last_gap[2]), 32'd3);
    check("b2b_rises",   32'(total_rise[2] - f), 32'd32);

`ifdef SPI_MASTER_LOOPBACK_EN
    // Loopback read returns the written byte.
    loopback[0] = 1'b1;
    slave_byte[0] = 8'h00;
    send(0, 7'h12, 1'b1, 8'hA5, 1'b0, 1'b1);
    finish_frame(0, 300);
    loopback[0] = 1'b0;
`endif

    repeat (20) @(negedge clk);
    for (int i = 0; i < N; i++) begin
      check($sformatf("done_width%0d", i),   32'(done_long[i]),    32'd0);
      check($sformatf("rise_cs_high%0d", i), 32'(rise_cs_high[i]), 32'd0);
    end
    check("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
